alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters (e.g. issue and address-gen paths).
//  Round-robin arbitration; a valid/ready handshake on each request port and on the result port.
//  Result is held in a single-entry output register, so latency is 1 cycle and throughput is 1 op/cycle.
//  Result carries the winning requester's ID.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  OPW     3   opcode width
// PORTS
//  clk         in   1      clock, all state on posedge
//  rst         in   1      asynchronous, active-high reset
//  req0_valid  in   1      requester 0 has an op
//  req0_op     in   OPW    requester 0 opcode
//  req0_rs1    in   WIDTH  requester 0 operand A
//  req0_rs2    in   WIDTH  requester 0 operand B
//  req0_ready  out  1      requester 0 op accepted this cycle (valid & ready)
//  req1_*      --   --     same set for requester 1
//  res_valid   out  1      res_rd/res_id hold a result
//  res_rd      out  WIDTH  result
//  res_id      out  1      requester that issued the result
//  res_ready   in   1      consumer takes the result this cycle
// BEHAVIOUR
//  Reset (async, rst=1): res_valid=0, res_rd=0, res_id=0, last_grant=1.
//  - The reset value of last_grant=1 means requester 0 wins the first contention.
//  Opcodes (normative; result computed mod 2^WIDTH):
//  - 0 ADD: rs1+rs2
//  - 1 SUB: rs1-rs2
//  - 2 AND, 3 OR, 4 XOR
//  - 5 SLT: signed compare; result 1 if rs1<rs2, else 0
//  - 6 SLL / 7 SRL: shift amount = rs2[$clog2(WIDTH)-1:0]; SRL is a logical shift
//  Output register FSM:
//  - States EMPTY (res_valid=0) and FULL (res_valid=1).
//  - can_accept = EMPTY | (FULL & res_ready).
//  Grant (combinational):
//  - Only one valid: that requester gets the grant.
//  - Both valid: the requester != last_grant gets the grant.
//  - reqN_ready = grant_N & can_accept. Ready may depend on valid; valid must never depend on ready.
//  Transfer on posedge when reqN_valid & reqN_ready:
//  - res_rd <= ALU(op, rs1, rs2); res_id <= N; res_valid <= 1; last_grant <= N.
//  Drain: FULL & res_ready & no transfer -> EMPTY; res_rd/res_id keep their values.
//  Simultaneous drain and transfer: stay FULL and load the new result. There is no bubble.
//  FULL & !res_ready: both readys=0; res_rd/res_id/res_id stable until accepted.
//  Requester holding valid: must keep op/rs1/rs2 stable until ready. The arbiter does not latch operands early.
//  last_grant updates only on an accepted transfer; a refused request does not move the pointer.
//  Reset mid-operation: any pending result is discarded. First post-reset grant follows the reset values.
//  Opcode >= 8 when OPW > 3: result 0.
// CONFIGURATION
//  ALU_ARB_PERF_EN defined:
//  - Adds ports perf_gnt0 and perf_gnt1 (out, 32 bits each): accepted-transfer counts per requester.
//  - Adds port perf_stall (out, 32 bits): cycles with any reqN_valid=1 and both readys=0.
//  - Counters wrap at 2^32 and reset to 0 on rst.
//  ALU_ARB_PERF_EN undefined:
//  - No counter ports and no counter logic.
//  - The arbitration/result behaviour above is otherwise identical.
// TESTING
//  1) Reset, then req0 SUB rs1=10 rs2=-10, res_ready=1
//     -> next cycle res_valid=1, res_rd=20, res_id=0.
//  2) Both valid every cycle, res_ready=1; req0 ADD 1,1 and req1 SUB -10,10
//     -> ids alternate 0,1,0,1; rd alternates 2, 0xFFFFFFEC.
//  3) res_ready=0 with result 4294967295-(-1)=0 held for 5 cycles, req1 valid
//     -> res_valid=1, rd=0 stable; req1_ready=0 throughout.
//     -> then res_ready=1: req1 accepted the same cycle, with no bubble.
//  4) SLT 0x80000000,1 -> 1. SRL 0x80000000,33 -> 0x40000000. SLL 1,31 -> 0x80000000.
//  5) Assert rst while FULL with res_ready=0
//     -> res_valid=0 immediately (async); after release req0 wins the first contention.
//  6) ALU_ARB_PERF_EN defined: 6 transfers (4 req0, 2 req1) and 3 stall cycles
//     -> perf_gnt0=4, perf_gnt1=2, perf_stall=3.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one combinational ALU, with a
// single-entry result register. Define ALU_ARB_PERF_EN to add grant/stall counters.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_rs1,
  input  logic [WIDTH-1:0] req0_rs2,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_rs1,
  input  logic [WIDTH-1:0] req1_rs2,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_rd,
  output logic             res_id,
  input  logic             res_ready
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]      perf_gnt0,
  output logic [31:0]      perf_gnt1,
  output logic [31:0]      perf_stall
`endif
);

  // Handshake: a port transfers on a posedge where valid & ready are both 1.
  // Ready may depend on valid; valid never depends on ready.
  localparam int SHW = $clog2(WIDTH);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    int unsigned    opi;
    sh  = b[SHW-1:0];
    opi = 32'(op);
    case (opi)
      0:       alu_f = a + b;
      1:       alu_f = a - b;
      2:       alu_f = a & b;
      3:       alu_f = a | b;
      4:       alu_f = a ^ b;
      5:       alu_f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      6:       alu_f = a << sh;
      7:       alu_f = a >> sh;
      default: alu_f = '0;
    endcase
  endfunction

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] res_rd_q, res_rd_d;
  logic             res_id_q, res_id_d;
  logic             last_grant_q, last_grant_d;
  logic             grant0, grant1, can_accept, xfer;

  always_comb begin
    grant0       = req0_valid & (~req1_valid | last_grant_q);
    grant1       = req1_valid & (~req0_valid | ~last_grant_q);
    can_accept   = (state_q == ST_EMPTY) | res_ready;
    req0_ready   = grant0 & can_accept;
    req1_ready   = grant1 & can_accept;
    xfer         = req0_ready | req1_ready;
    state_d      = state_q;
    res_rd_d     = res_rd_q;
    res_id_d     = res_id_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      // A load while draining keeps the register FULL, so there is no bubble.
      state_d      = ST_FULL;
      res_id_d     = req1_ready;
      last_grant_d = req1_ready;
      res_rd_d     = req1_ready ? alu_f(req1_op, req1_rs1, req1_rs2)
                                : alu_f(req0_op, req0_rs1, req0_rs2);
    end else if ((state_q == ST_FULL) && res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      res_rd_q     <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      res_rd_q     <= res_rd_d;
      res_id_q     <= res_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_rd    = res_rd_q;
  assign res_id    = res_id_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_gnt0_q, perf_gnt0_d;
  logic [31:0] perf_gnt1_q, perf_gnt1_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_gnt0_d  = perf_gnt0_q + 32'(req0_ready);
    perf_gnt1_d  = perf_gnt1_q + 32'(req1_ready);
    perf_stall_d = perf_stall_q + 32'((req0_valid | req1_valid) & ~xfer);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_gnt0_q  <= perf_gnt0_d;
      perf_gnt1_q  <= perf_gnt1_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_gnt0  = perf_gnt0_q;
  assign perf_gnt1  = perf_gnt1_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, ALU ops, round-robin, backpressure,
// async reset mid-operation, and the optional counters.
module tb_alu_arbiter;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic        res_valid, res_id, res_ready;
  logic [31:0] res_rd;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_gnt0, perf_gnt1, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [2:0]  vec_op [10];
  logic [31:0] vec_a  [10];
  logic [31:0] vec_b  [10];
  logic [31:0] vec_e  [10];

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_rs1(req0_rs1),
    .req0_rs2(req0_rs2), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_rs1(req1_rs1),
    .req1_rs2(req1_rs2), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_rd(res_rd), .res_id(res_id), .res_ready(res_ready)
`ifdef ALU_ARB_PERF_EN
    , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (res_valid !== 1'b0 || res_rd !== 32'd0 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b rd=%h id=%b required 0 0 0", res_valid, res_rd, res_id);
    end
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    drive0(1'b1, 3'd1, 32'd10, -32'sd10);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: r0=%b r1=%b required 1 0", req0_ready, req1_ready);
    end
    tick();
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    checks++;
    if (res_valid !== 1'b1 || res_rd !== 32'd20 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL single_result: valid=%b rd=%0d id=%b required 1 20 0", res_valid, res_rd, res_id);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || res_rd !== 32'd20) begin
      errors++;
      $display("FAIL single_drain: valid=%b rd=%0d required 0 20", res_valid, res_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    do_reset();
    res_ready = 1'b1;
    drive0(1'b1, 3'd0, 32'd1, 32'd1);
    drive1(1'b1, 3'd1, -32'sd10, 32'd10);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_rd = (i % 2 == 0) ? 32'd2 : 32'hFFFF_FFEC;
      checks++;
      if (res_valid !== 1'b1 || res_id !== 1'((i % 2)) || res_rd !== exp_rd) begin
        errors++;
        $display("FAIL rr_%0d: valid=%b id=%b rd=%h required 1 %0d %h", i, res_valid, res_id, res_rd, i % 2, exp_rd);
      end
    end
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 1'b0;
    drive0(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b1, 3'd0, 32'd5, 32'd6);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_rd !== 32'd0 || res_id !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b rd=%h id=%b r1=%b required 1 0 0 0", i, res_valid, res_rd, res_id, req1_ready);
      end
      tick();
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: r1=%b required 1", req1_ready);
    end
    tick();
    drive1(1'b0, 3'd0, 32'd0, 32'd0);
    checks++;
    if (res_valid !== 1'b1 || res_rd !== 32'd11 || res_id !== 1'b1) begin
      errors++;
      $display("FAIL release_result: valid=%b rd=%0d id=%b required 1 11 1", res_valid, res_rd, res_id);
    end
    tick();
  endtask

  task automatic test_alu_ops();
    vec_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd7};
    vec_a  = '{32'hFFFF_FFFF, 32'd3, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_00FF,
               32'h8000_0000, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000};
    vec_b  = '{32'd1, 32'd5, 32'h0000_FF00, 32'h0000_0F0F, 32'h0000_000F,
               32'd1, 32'h8000_0000, 32'd31, 32'd33, 32'd31};
    vec_e  = '{32'd0, 32'hFFFF_FFFE, 32'h0000_F000, 32'h0000_FFFF, 32'h0000_00F0,
               32'd1, 32'd0, 32'h8000_0000, 32'h4000_0000, 32'd1};
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, vec_op[i], vec_a[i], vec_b[i]);
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_rd !== vec_e[i]) begin
        errors++;
        $display("FAIL alu_op%0d_v%0d: valid=%b rd=%h required 1 %h", vec_op[i], i, res_valid, res_rd, vec_e[i]);
      end
    end
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    res_ready = 1'b0;
    drive0(1'b1, 3'd0, 32'd7, 32'd8);
    tick();
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_rd !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b rd=%h required 0 0", res_valid, res_rd);
    end
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    drive0(1'b1, 3'd0, 32'd1, 32'd2);
    drive1(1'b1, 3'd0, 32'd3, 32'd4);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_grant: r0=%b r1=%b required 1 0", req0_ready, req1_ready);
    end
    tick();
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0);
    checks++;
    if (res_id !== 1'b0 || res_rd !== 32'd3) begin
      errors++;
      $display("FAIL post_reset_result: id=%b rd=%0d required 0 3", res_id, res_rd);
    end
    tick();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++;
    if (perf_gnt0 !== 32'd0 || perf_gnt1 !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: g0=%0d g1=%0d st=%0d required 0 0 0", perf_gnt0, perf_gnt1, perf_stall);
    end
    res_ready = 1'b1;
    drive0(1'b1, 3'd0, 32'd1, 32'd1);
    repeat (3) tick();
    drive1(1'b1, 3'd0, 32'd2, 32'd2);
    repeat (2) tick();
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    res_ready = 1'b0;
    repeat (3) tick();
    res_ready = 1'b1;
    tick();
    drive1(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    checks++;
    if (perf_gnt0 !== 32'd4 || perf_gnt1 !== 32'd2 || perf_stall !== 32'd3) begin
      errors++;
      $display("FAIL perf_counts: g0=%0d g1=%0d st=%0d required 4 2 3", perf_gnt0, perf_gnt1, perf_stall);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_alu_ops();
    test_reset_mid();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
